char_anim_sequencer: RTL and testbench
======================================

Name: char_anim_sequencer

Overview:
- Frame-synchronous state machine that selects the character sprite for the character display controller.
- Outputs `char_id` (0..6, same encoding as the display controller) and `char_face`; both are updated only on `frame_tick`, so the sprite cannot change mid-frame.
- Inputs come from the physics/motion block: ground contact, vertical velocity, charge button, landing severity.
- Adds idle animation, landing hold time and charge/idle debounce.

Parameters:
- VY_WIDTH, 8, width of signed vertical velocity (negative = upward on screen).
- CNT_WIDTH, 8, width of the per-state frame counter.
- IDLE_TOGGLE_FRAMES, 30, frames between IDLE_1 and IDLE_2 swaps.
- LAND_HOLD_FRAMES, 20, frames FALL_TO_GROUND is held.
- SAFE_HOLD_FRAMES, 6, frames SAFE_GROUND is held.
- MIN_HOLD_FRAMES, 2, minimum frames before a CHARGE<->IDLE change.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset: one clock; reset is synchronous and active-high.
- frame_tick  in  1  one-cycle pulse at vblank start.
- char_on_ground  in  1  character resting on a platform.
- char_vy  in  VY_WIDTH signed  vertical velocity.
- char_charging  in  1  jump charge held.
- hard_landing  in  1  pulse: landing after a long fall; may occur on any cycle.
- char_dir_in  in  2 signed  requested facing (-1 = 2'b11, +1 = 2'b01, 0 = none).
- char_id  out  3  sprite select.
- char_face  out  2 signed  facing.
- anim_update  out  1  one-cycle pulse when char_id changes.
- move_lock  out  1  high while in FALL_TO_GROUND; motion block ignores inputs.

Behaviour:
Reset values:
- sys_rst (synchronous) forces state IDLE_1 and char_id=0.
- char_face=2'b01, frame_cnt=0, hard-landing latch=0, anim_update=0, move_lock=0.
- Reset asserted mid-hold abandons the hold immediately.

States (char_id = state code):
- IDLE_1=0, IDLE_2=1, CHARGE=2, JUMP_UP=3, JUMP_DOWN=4, FALL_TO_GROUND=5, SAFE_GROUND=6.
- Codes 7 are never produced.

Timing and counter:
- All transitions are evaluated only in a cycle where frame_tick=1.
- char_id, char_face and anim_update register one cycle after the tick.
- frame_cnt clears on every state change. Otherwise it increments on each tick, saturating at 2^CNT_WIDTH-1.

Hard-landing latch:
- hard_landing sets a sticky latch.
- A pulse coincident with a tick counts for that tick.
- The latch clears when a landing state is entered, and on any tick where char_on_ground=0 and state is not airborne (stale event).

Transition priority on a tick:
1. FALL_TO_GROUND: hold until frame_cnt >= LAND_HOLD_FRAMES-1, then go to IDLE_1. All other inputs are ignored, including loss of ground.
2. char_on_ground=0:
   - char_vy<0 → JUMP_UP; otherwise JUMP_DOWN.
   - vy=0 → JUMP_DOWN.
   - Immediate, no debounce; this also applies from SAFE_GROUND.
3. char_on_ground=1 while state is JUMP_UP or JUMP_DOWN: latch set → FALL_TO_GROUND, else → SAFE_GROUND.
4. SAFE_GROUND: hold until frame_cnt >= SAFE_HOLD_FRAMES-1, then → CHARGE if char_charging, else → IDLE_1.
5. Idle/charge, with frame_cnt >= MIN_HOLD_FRAMES-1 required:
   - IDLE_x and char_charging=1 → CHARGE.
   - CHARGE and char_charging=0 → IDLE_1.
6. IDLE_1 and IDLE_2 swap when frame_cnt >= IDLE_TOGGLE_FRAMES-1.

Outputs:
- char_face updates on a tick only when char_dir_in is nonzero and the next state is IDLE_x or CHARGE. It is frozen while airborne or landing.
- move_lock is a registered decode of state==FALL_TO_GROUND.
- anim_update pulses in the cycle the new char_id first appears.

Optional Feature:
CHAR_ANIM_FORCE_EN:
- Defined: adds ports force_en (in, 1) and force_id (in, 3).
- While force_en=1, char_id=force_id on the next tick. force_id=7 is clamped to 0.
- The FSM keeps running underneath. When force_en drops, the true state is shown on the next tick.
- anim_update is computed on the displayed id.
- Undefined: the ports are absent and char_id is the state.

Decomposition:
- char_anim_pkg holds:
  - the 3-bit state/sprite codes, shared with the display controller;
  - face codes FACE_LEFT=2'b11 and FACE_RIGHT=2'b01;
  - the default hold constants.
- One sub-module, frame_hold_counter:
  - tick-enabled, clear-on-change, saturating counter;
  - has a terminal-compare output against a runtime limit.

Test Plan:
1. Reset, on_ground=1, no charge; 61 ticks → char_id 0→1 at tick 30 and 1→0 at tick 60; anim_update pulses twice; char_face=01.
2. Idle, charging=1 for exactly 1 tick then 0 → enter CHARGE after the tick; release is ignored until frame_cnt reaches 1 (MIN_HOLD), then IDLE_1.
3. Jump: on_ground=0, vy=-5 → 3; vy=+4 → 4; on_ground=1 with no hard_landing → 6 for 6 ticks, then 0.
4. Fall: JUMP_DOWN, hard_landing pulsed between ticks, then on_ground=1 → 5 with move_lock=1 for 20 ticks. charging=1 and on_ground=0 during the hold are ignored; afterwards → IDLE_1, then CHARGE.
5. char_dir_in=11 while airborne → char_face unchanged; after landing in SAFE_GROUND, char_dir_in=11 during IDLE → char_face=11.
6. sys_rst asserted at tick 10 of FALL_TO_GROUND → next cycle char_id=0, move_lock=0, latch clear. With CHAR_ANIM_FORCE_EN: force_en=1, force_id=7 → char_id=0.

Source files
------------

// File: rtl/char_anim_sequencer_pkg.sv
// Shared sprite/state codes, facing codes and default hold lengths for the
// character animation sequencer and the display controller.
package char_anim_pkg;

  localparam logic [2:0] ST_IDLE_1         = 3'd0;
  localparam logic [2:0] ST_IDLE_2         = 3'd1;
  localparam logic [2:0] ST_CHARGE         = 3'd2;
  localparam logic [2:0] ST_JUMP_UP        = 3'd3;
  localparam logic [2:0] ST_JUMP_DOWN      = 3'd4;
  localparam logic [2:0] ST_FALL_TO_GROUND = 3'd5;
  localparam logic [2:0] ST_SAFE_GROUND    = 3'd6;

  localparam logic [1:0] FACE_LEFT  = 2'b11;
  localparam logic [1:0] FACE_RIGHT = 2'b01;

  localparam int DEF_IDLE_TOGGLE_FRAMES = 30;
  localparam int DEF_LAND_HOLD_FRAMES   = 20;
  localparam int DEF_SAFE_HOLD_FRAMES   = 6;
  localparam int DEF_MIN_HOLD_FRAMES    = 2;

  function automatic logic is_airborne(input logic [2:0] s);
    return (s == ST_JUMP_UP) || (s == ST_JUMP_DOWN);
  endfunction

  // States in which the player may turn the character around.
  function automatic logic is_steerable(input logic [2:0] s);
    return (s == ST_IDLE_1) || (s == ST_IDLE_2) || (s == ST_CHARGE);
  endfunction

endpackage

// File: rtl/char_anim_sequencer_frame_hold_counter.sv
// Frame-tick driven hold counter: clears on a state change, otherwise counts
// ticks and saturates; o_reached compares against a runtime limit.
module frame_hold_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 i_clear,
  input  logic [CNT_WIDTH-1:0] i_limit,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_reached
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_tick) begin
      if (i_clear) begin
        r_count <= '0;
      end else if (r_count != '1) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_reached = (r_count >= i_limit);

endmodule

// File: rtl/char_anim_sequencer.sv
// Frame-synchronous sprite selector: picks char_id/char_face once per frame
// from ground contact, velocity and charge. Optional macro: CHAR_ANIM_FORCE_EN.
module char_anim_sequencer
  import char_anim_pkg::*;
#(
  parameter int VY_WIDTH           = 8,
  parameter int CNT_WIDTH          = 8,
  parameter int IDLE_TOGGLE_FRAMES = DEF_IDLE_TOGGLE_FRAMES,
  parameter int LAND_HOLD_FRAMES   = DEF_LAND_HOLD_FRAMES,
  parameter int SAFE_HOLD_FRAMES   = DEF_SAFE_HOLD_FRAMES,
  parameter int MIN_HOLD_FRAMES    = DEF_MIN_HOLD_FRAMES
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       frame_tick,
  input  logic                       char_on_ground,
  input  logic signed [VY_WIDTH-1:0] char_vy,
  input  logic                       char_charging,
  input  logic                       hard_landing,
  input  logic signed [1:0]          char_dir_in,
`ifdef CHAR_ANIM_FORCE_EN
  input  logic                       force_en,
  input  logic [2:0]                 force_id,
`endif
  output logic [2:0]                 char_id,
  output logic signed [1:0]          char_face,
  output logic                       anim_update,
  output logic                       move_lock
);

  localparam logic [CNT_WIDTH-1:0] LIM_TOGGLE = CNT_WIDTH'(IDLE_TOGGLE_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] LIM_LAND   = CNT_WIDTH'(LAND_HOLD_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] LIM_SAFE   = CNT_WIDTH'(SAFE_HOLD_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] LIM_MIN    = CNT_WIDTH'(MIN_HOLD_FRAMES - 1);
  localparam logic signed [VY_WIDTH-1:0] VY_ZERO = '0;

  logic [2:0]           r_state;
  logic [2:0]           r_char_id;
  logic signed [1:0]    r_face;
  logic                 r_latch;
  logic                 r_anim;
  logic                 r_lock;
  logic [2:0]           w_state_next;
  logic [2:0]           w_disp_next;
  logic signed [1:0]    w_face_next;
  logic                 w_latch_eff;
  logic                 w_latch_next;
  logic                 w_state_chg;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic [CNT_WIDTH-1:0] w_limit;
  logic                 w_reached;
  logic                 w_min_ok;

  // A hard-landing pulse in the tick cycle itself must already count.
  assign w_latch_eff = r_latch | hard_landing;
  assign w_min_ok    = (w_cnt >= LIM_MIN);
  assign w_state_chg = (w_state_next != r_state);

  always_comb begin
    w_limit = LIM_MIN;
    case (r_state)
      ST_IDLE_1, ST_IDLE_2: w_limit = LIM_TOGGLE;
      ST_FALL_TO_GROUND:    w_limit = LIM_LAND;
      ST_SAFE_GROUND:       w_limit = LIM_SAFE;
      default:              w_limit = LIM_MIN;
    endcase
  end

  frame_hold_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hold (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .i_tick    (frame_tick),
    .i_clear   (w_state_chg),
    .i_limit   (w_limit),
    .o_count   (w_cnt),
    .o_reached (w_reached)
  );

  always_comb begin
    w_state_next = r_state;
    if (frame_tick) begin
      if (r_state == ST_FALL_TO_GROUND) begin
        if (w_reached) w_state_next = ST_IDLE_1;
      end else if (!char_on_ground) begin
        w_state_next = (char_vy < VY_ZERO) ? ST_JUMP_UP : ST_JUMP_DOWN;
      end else if (is_airborne(r_state)) begin
        w_state_next = w_latch_eff ? ST_FALL_TO_GROUND : ST_SAFE_GROUND;
      end else begin
        case (r_state)
          ST_SAFE_GROUND: begin
            if (w_reached) w_state_next = char_charging ? ST_CHARGE : ST_IDLE_1;
          end
          ST_CHARGE: begin
            if (!char_charging && w_reached) w_state_next = ST_IDLE_1;
          end
          ST_IDLE_1, ST_IDLE_2: begin
            if (char_charging && w_min_ok) w_state_next = ST_CHARGE;
            else if (w_reached) w_state_next = (r_state == ST_IDLE_1) ? ST_IDLE_2 : ST_IDLE_1;
          end
          default: w_state_next = ST_IDLE_1;
        endcase
      end
    end
  end

  // Latch drops on entering a landing state, or when leaving the ground from
  // a grounded state (the event belonged to an earlier fall).
  always_comb begin
    w_latch_next = w_latch_eff;
    if (frame_tick) begin
      if (w_state_chg && ((w_state_next == ST_FALL_TO_GROUND) ||
                          (w_state_next == ST_SAFE_GROUND)))
        w_latch_next = 1'b0;
      if (!char_on_ground && !is_airborne(r_state))
        w_latch_next = 1'b0;
    end
  end

  always_comb begin
    w_face_next = r_face;
    if (frame_tick && (char_dir_in != 2'sb00) && is_steerable(w_state_next))
      w_face_next = char_dir_in;
  end

  always_comb begin
`ifdef CHAR_ANIM_FORCE_EN
    if (force_en) w_disp_next = (force_id == 3'd7) ? ST_IDLE_1 : force_id;
    else          w_disp_next = w_state_next;
`else
    w_disp_next = w_state_next;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE_1;
      r_char_id <= ST_IDLE_1;
      r_face    <= FACE_RIGHT;
      r_latch   <= 1'b0;
      r_anim    <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_latch <= w_latch_next;
      r_lock  <= (w_state_next == ST_FALL_TO_GROUND);
      r_anim  <= 1'b0;
      if (frame_tick) begin
        r_char_id <= w_disp_next;
        r_face    <= w_face_next;
        r_anim    <= (w_disp_next != r_char_id);
      end
    end
  end

  assign char_id     = r_char_id;
  assign char_face   = r_face;
  assign anim_update = r_anim;
  assign move_lock   = r_lock;

endmodule

// File: tb/tb_char_anim_sequencer.sv
// Bench for char_anim_sequencer: directed scenarios then randomized frames,
// checked against a rule-level reference model through an expected queue.
module tb_char_anim_sequencer;

  localparam int S_IDLE1 = 0, S_IDLE2 = 1, S_CHARGE = 2, S_JUP = 3;
  localparam int S_JDOWN = 4, S_FALL = 5, S_SAFE = 6;
  localparam int TOGGLE = 30, LAND = 20, SAFEH = 6, MINH = 2, CNT_MAX = 255;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              frame_tick = 1'b0;
  logic              char_on_ground = 1'b1;
  logic signed [7:0] char_vy = '0;
  logic              char_charging = 1'b0;
  logic              hard_landing = 1'b0;
  logic signed [1:0] char_dir_in = '0;
  logic              force_en = 1'b0;
  logic [2:0]        force_id = '0;
  logic [2:0]        char_id;
  logic signed [1:0] char_face;
  logic              anim_update;
  logic              move_lock;

  always #5 sys_clk = ~sys_clk;

  char_anim_sequencer dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .frame_tick     (frame_tick),
    .char_on_ground (char_on_ground),
    .char_vy        (char_vy),
    .char_charging  (char_charging),
    .hard_landing   (hard_landing),
    .char_dir_in    (char_dir_in),
`ifdef CHAR_ANIM_FORCE_EN
    .force_en       (force_en),
    .force_id       (force_id),
`endif
    .char_id        (char_id),
    .char_face      (char_face),
    .anim_update    (anim_update),
    .move_lock      (move_lock)
  );

  // Reference model state
  int         m_state, m_cnt, m_disp;
  bit         m_latch;
  logic [1:0] m_face;
  logic [6:0] exp_q[$];
  int         n_cmp = 0, n_fail = 0;
  bit         mon_en = 0;

  function automatic bit grounded_idle(input int s);
    return (s == S_IDLE1) || (s == S_IDLE2) || (s == S_CHARGE);
  endfunction

  // One frame by the rules, using the inputs currently driven.
  task automatic model_tick();
    int  nxt, disp;
    bit  lat, g, chg, anim;
    int  vy;
    g   = char_on_ground;
    chg = char_charging;
    vy  = int'(char_vy);
    lat = m_latch || hard_landing;
    nxt = m_state;
    if (m_state == S_FALL) begin
      if (m_cnt >= LAND - 1) nxt = S_IDLE1;
    end else if (!g) begin
      nxt = (vy < 0) ? S_JUP : S_JDOWN;
    end else if (m_state == S_JUP || m_state == S_JDOWN) begin
      nxt = lat ? S_FALL : S_SAFE;
    end else if (m_state == S_SAFE) begin
      if (m_cnt >= SAFEH - 1) nxt = chg ? S_CHARGE : S_IDLE1;
    end else if (m_state == S_CHARGE) begin
      if (!chg && m_cnt >= MINH - 1) nxt = S_IDLE1;
    end else if (chg && m_cnt >= MINH - 1) begin
      nxt = S_CHARGE;
    end else if (m_cnt >= TOGGLE - 1) begin
      nxt = (m_state == S_IDLE1) ? S_IDLE2 : S_IDLE1;
    end
    if ((nxt == S_FALL || nxt == S_SAFE) && nxt != m_state) lat = 0;
    if (!g && m_state != S_JUP && m_state != S_JDOWN) lat = 0;
    if (nxt != m_state) m_cnt = 0;
    else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    if (char_dir_in != 2'b00 && grounded_idle(nxt)) m_face = char_dir_in;
    disp = nxt;
`ifdef CHAR_ANIM_FORCE_EN
    if (force_en) disp = (force_id == 3'd7) ? 0 : int'(force_id);
`endif
    anim    = (disp != m_disp);
    m_disp  = disp;
    m_state = nxt;
    m_latch = lat;
    exp_q.push_back({3'(disp), m_face, anim, (nxt == S_FALL)});
  endtask

  task automatic drive(input bit tk, input bit g, input int vy, input bit chg,
                       input bit hl, input logic [1:0] dir);
    frame_tick     = tk;
    char_on_ground = g;
    char_vy        = 8'(vy);
    char_charging  = chg;
    hard_landing   = hl;
    char_dir_in    = dir;
    if (tk) model_tick();
    else if (hl) m_latch = 1;
    @(posedge sys_clk);
    #1;
    frame_tick   = 1'b0;
    hard_landing = 1'b0;
  endtask

  // One frame: a tick followed by a quiet gap cycle.
  task automatic frame(input bit g, input int vy, input bit chg, input logic [1:0] dir);
    drive(1, g, vy, chg, 0, dir);
    drive(0, g, vy, chg, 0, dir);
  endtask

  task automatic do_reset();
    mon_en       = 1;
    sys_rst      = 1'b1;
    frame_tick   = 1'b0;
    hard_landing = 1'b0;
    m_state = S_IDLE1;
    m_cnt   = 0;
    m_latch = 0;
    m_face  = 2'b01;
    m_disp  = 0;
    exp_q.push_back({3'd0, 2'b01, 1'b0, 1'b0});
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  // Monitor: tick and reset cycles pop the queue; other cycles must hold.
  initial begin
    logic [6:0] e, got;
    logic [2:0] last_id;
    logic       last_lock;
    bit         tk, rs, en;
    last_id   = '0;
    last_lock = 1'b0;
    forever begin
      @(posedge sys_clk);
      tk = frame_tick;
      rs = sys_rst;
      en = mon_en;
      @(negedge sys_clk);
      got = {char_id, char_face, anim_update, move_lock};
      if (en && (rs || tk)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL empty_queue got %b with no expectation at %0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL %s got id=%0d face=%b anim=%b lock=%b, want id=%0d face=%b anim=%b lock=%b at %0t",
                     rs ? "reset_out" : "tick_out", got[6:4], got[3:2], got[1], got[0],
                     e[6:4], e[3:2], e[1], e[0], $time);
          end
          last_id   = e[6:4];
          last_lock = e[0];
        end
      end else if (en) begin
        n_cmp++;
        if (anim_update !== 1'b0 || char_id !== last_id || move_lock !== last_lock) begin
          n_fail++;
          $display("FAIL between_ticks got id=%0d anim=%b lock=%b, want id=%0d anim=0 lock=%b at %0t",
                   char_id, anim_update, move_lock, last_id, last_lock, $time);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g, chg;
    logic [1:0] dir;
    @(posedge sys_clk);
    #1;
    do_reset();

    // Idle animation: swap at tick 30 and back at tick 60.
    for (int i = 0; i < 61; i++) frame(1, 0, 0, 2'b00);
    // Short charge press, release honoured only after the minimum hold.
    frame(1, 0, 1, 2'b00);
    for (int i = 0; i < 3; i++) frame(1, 0, 0, 2'b00);
    // Soft jump: up, down, safe landing hold, back to idle.
    frame(0, -5, 0, 2'b00);
    frame(0, 4, 0, 2'b00);
    for (int i = 0; i < 8; i++) frame(1, 0, 0, 2'b00);
    // Hard landing pulsed between ticks, hold ignores charge and ground loss.
    frame(0, 4, 0, 2'b00);
    drive(0, 0, 4, 0, 1, 2'b00);
    frame(1, 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) frame(i[0], 3, 1, 2'b00);
    for (int i = 0; i < 12; i++) frame(1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) frame(1, 0, 1, 2'b00);
    // Facing frozen airborne and in landing hold, follows input in idle.
    frame(0, 3, 0, 2'b11);
    for (int i = 0; i < 9; i++) frame(1, 0, 0, 2'b11);
    // Reset in the middle of a hard-landing hold.
    frame(0, 2, 0, 2'b00);
    drive(1, 1, 0, 0, 1, 2'b00);
    drive(0, 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) frame(1, 0, 0, 2'b00);
    do_reset();
    frame(1, 0, 0, 2'b00);
`ifdef CHAR_ANIM_FORCE_EN
    force_en = 1'b1;
    force_id = 3'd7;
    frame(1, 0, 0, 2'b00);
    force_id = 3'd4;
    frame(1, 0, 0, 2'b00);
    force_en = 1'b0;
    frame(1, 0, 0, 2'b00);
`endif

    // Randomized frames with sticky ground/charge and stray landing pulses.
    g = 1;
    chg = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 11) == 0) g = ~g;
      if ($urandom_range(0, 4) == 0) chg = ~chg;
      case ($urandom_range(0, 3))
        0:       dir = 2'b01;
        1:       dir = 2'b11;
        default: dir = 2'b00;
      endcase
`ifdef CHAR_ANIM_FORCE_EN
      if ($urandom_range(0, 19) == 0) force_en = ~force_en;
      force_id = 3'($urandom_range(0, 7));
`endif
      drive(1, g, int'($urandom_range(0, 16)) - 8, chg, ($urandom_range(0, 9) == 0), dir);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        drive(0, g, 0, chg, ($urandom_range(0, 7) == 0), dir);
    end

    repeat (3) drive(0, g, 0, chg, 0, 2'b00);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_queue got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
